// File: rtl/ad7843_pkg.sv
// ---------------------------------------------------------------------------
// ad7843_pkg
// Shared definitions for the AD7843 touch-screen digitizer emulator:
// channel codes, command FSM states, control-byte field positions, result
// widths and the result-selection helper.
// ---------------------------------------------------------------------------
package ad7843_pkg;

  // Channel select codes (A2:A0) that return real panel coordinates
  localparam logic [2:0] CH_X = 3'b001;
  localparam logic [2:0] CH_Y = 3'b101;

  // Control byte layout: S A2 A1 A0 MODE SER/DFR PD1 PD0
  localparam int CMD_ADDR_MSB = 6;
  localparam int CMD_ADDR_LSB = 4;
  localparam int CMD_MODE_BIT = 3;
  localparam int CMD_PD0_BIT  = 0;

  // Conversion result widths
  localparam int RES_WIDTH   = 12;
  localparam int RES_WIDTH_8 = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_BUSY,
    ST_LOAD
  } cmdState_t;

  // Picks the conversion word for a channel. In 8-bit mode only the top
  // eight bits survive; the low nibble is zeroed so the shifter naturally
  // emits zeros after the eighth bit.
  function automatic logic [RES_WIDTH-1:0] selectResult(
    input logic [2:0]           addr,
    input logic                 mode8,
    input logic [RES_WIDTH-1:0] xVal,
    input logic [RES_WIDTH-1:0] yVal,
    input logic [RES_WIDTH-1:0] auxVal
  );
    logic [RES_WIDTH-1:0] res;
    case (addr)
      CH_X:    res = xVal;
      CH_Y:    res = yVal;
      default: res = auxVal;
    endcase
    if (mode8) begin
      res = {res[RES_WIDTH-1 -: RES_WIDTH_8], {(RES_WIDTH-RES_WIDTH_8){1'b0}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/ad7843_sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Brings an asynchronous pin into the clk domain through STAGES flops, then
// one extra flop for edge detection.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset (all flops go to RESET_VAL)
//   i_async  asynchronous input pin
//   o_level  synchronized level
//   o_rise   one-clk strobe on a synchronized 0->1 transition
//   o_fall   one-clk strobe on a synchronized 1->0 transition
// STAGES must be at least 2.
// ---------------------------------------------------------------------------
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/ad7843_responder.sv
// ---------------------------------------------------------------------------
// ad7843_responder
// Emulates the serial side of an AD7843 touch-screen digitizer so the LT24
// touch driver can run without the physical panel.
// Ports:
//   clk, reset_n        system clock (>= 8x dclk), synchronous active-low reset
//   touch               1 while the emulated panel is pressed
//   x_value, y_value    12-bit conversion results returned for X / Y
//   adc_dclk/cs_n/din   serial clock, chip select and control data (async)
//   adc_dout            serial result data, MSB first
//   adc_busy            high for one dclk period between command and data
//   adc_penirq_n        pen interrupt, active-low, held high while selected
//   cmd_valid           one-clk pulse when a control byte completes
//   last_cmd            most recent complete control byte
// ---------------------------------------------------------------------------
module ad7843_responder
  import ad7843_pkg::*;
#(
  parameter int                   SYNC_STAGES = 2,
  parameter logic [RES_WIDTH-1:0] AUX_VALUE   = 12'h000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 touch,
  input  logic [RES_WIDTH-1:0] x_value,
  input  logic [RES_WIDTH-1:0] y_value,
  input  logic                 adc_dclk,
  input  logic                 adc_cs_n,
  input  logic                 adc_din,
  output logic                 adc_dout,
  output logic                 adc_busy,
  output logic                 adc_penirq_n,
  output logic                 cmd_valid,
  output logic [7:0]           last_cmd
);

  logic w_dclkLevel, w_dclkRiseRaw, w_dclkFallRaw;
  logic w_csN, w_csRiseUnused, w_csFallUnused;
  logic w_din, w_dinRiseUnused, w_dinFallUnused;
  logic w_dclkRise, w_dclkFall;
  logic [7:0] w_cmdByte;
  logic [RES_WIDTH-1:0] w_result;

  cmdState_t            r_state;
  logic [2:0]           r_bitCnt;
  logic [6:0]           r_cmdShift;
  logic [2:0]           r_addr;
  logic                 r_mode;
  logic                 r_pd0;
  logic [RES_WIDTH-2:0] r_outShift;
  logic                 r_dout;
  logic                 r_busy;
  logic                 r_penirqN;
  logic                 r_cmdValid;
  logic [7:0]           r_lastCmd;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncDclk (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (adc_dclk),
    .o_level (w_dclkLevel),
    .o_rise  (w_dclkRiseRaw),
    .o_fall  (w_dclkFallRaw)
  );

  // cs_n resets high so the part starts deselected
  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncCs (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (adc_cs_n),
    .o_level (w_csN),
    .o_rise  (w_csRiseUnused),
    .o_fall  (w_csFallUnused)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncDin (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (adc_din),
    .o_level (w_din),
    .o_rise  (w_dinRiseUnused),
    .o_fall  (w_dinFallUnused)
  );

  // dclk edges only count while the part is selected; the level itself is
  // only needed through its strobes
  assign w_dclkRise = w_dclkRiseRaw & ~w_csN & w_dclkLevel;
  assign w_dclkFall = w_dclkFallRaw & ~w_csN & ~w_dclkLevel;

  // Completed control byte as it stands on the 8th rising edge
  assign w_cmdByte = {r_cmdShift, w_din};

  assign w_result = selectResult(r_addr, r_mode, x_value, y_value, AUX_VALUE);

  // Command FSM, output shifter and pen interrupt share one register block.
  // Deselect beats any dclk edge seen in the same cycle. The output shifter
  // runs on every selected falling edge regardless of the FSM state, which
  // is what lets a new command overlap the tail of the previous result;
  // a LOAD simply overwrites whatever is left in it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_bitCnt   <= 3'd0;
      r_cmdShift <= 7'd0;
      r_addr     <= 3'd0;
      r_mode     <= 1'b0;
      r_pd0      <= 1'b0;
      r_outShift <= '0;
      r_dout     <= 1'b0;
      r_busy     <= 1'b0;
      r_penirqN  <= 1'b1;
      r_cmdValid <= 1'b0;
      r_lastCmd  <= 8'h00;
    end else if (w_csN) begin
      r_state    <= ST_IDLE;
      r_bitCnt   <= 3'd0;
      r_cmdShift <= 7'd0;
      r_outShift <= '0;
      r_dout     <= 1'b0;
      r_busy     <= 1'b0;
      r_cmdValid <= 1'b0;
      r_penirqN  <= ~(touch & ~r_pd0);
    end else begin
      r_cmdValid <= 1'b0;
      r_penirqN  <= 1'b1;

      if (w_dclkRise) begin
        case (r_state)
          ST_IDLE: begin
            // Leading zeros are skipped until a start bit appears
            if (w_din) begin
              r_state    <= ST_CMD;
              r_bitCnt   <= 3'd1;
              r_cmdShift <= 7'd1;
            end
          end
          ST_CMD: begin
            if (r_bitCnt == 3'd7) begin
              r_lastCmd  <= w_cmdByte;
              r_cmdValid <= 1'b1;
              r_addr     <= w_cmdByte[CMD_ADDR_MSB:CMD_ADDR_LSB];
              r_mode     <= w_cmdByte[CMD_MODE_BIT];
              r_pd0      <= w_cmdByte[CMD_PD0_BIT];
              r_state    <= ST_BUSY;
            end else begin
              r_cmdShift <= {r_cmdShift[5:0], w_din};
              r_bitCnt   <= r_bitCnt + 3'd1;
            end
          end
          default: ;
        endcase
      end

      if (w_dclkFall) begin
        if (r_state == ST_LOAD) begin
          r_busy     <= 1'b0;
          r_dout     <= w_result[RES_WIDTH-1];
          r_outShift <= w_result[RES_WIDTH-2:0];
          r_state    <= ST_IDLE;
        end else begin
          r_dout     <= r_outShift[RES_WIDTH-2];
          r_outShift <= {r_outShift[RES_WIDTH-3:0], 1'b0};
          if (r_state == ST_BUSY) begin
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
          end
        end
      end
    end
  end

  assign adc_dout     = r_dout;
  assign adc_busy     = r_busy;
  assign adc_penirq_n = r_penirqN;
  assign cmd_valid    = r_cmdValid;
  assign last_cmd     = r_lastCmd;

endmodule

// File: tb/tb_ad7843_responder.sv
// ---------------------------------------------------------------------------
// tb_ad7843_responder
// Drives SPI-style frames into the AD7843 emulator. For each frame the
// expected dout/busy value at every dclk rise is planned from the control
// bytes and pushed to a scoreboard, then popped and compared as the frame
// is clocked out.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad7843_responder;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        touch = 1'b0;
  logic [11:0] x_value = 12'h000;
  logic [11:0] y_value = 12'h000;
  logic        adc_dclk = 1'b0;
  logic        adc_cs_n = 1'b1;
  logic        adc_din = 1'b0;
  logic        adc_dout;
  logic        adc_busy;
  logic        adc_penirq_n;
  logic        cmd_valid;
  logic [7:0]  last_cmd;

  ad7843_responder #(.SYNC_STAGES(SYNC_STAGES), .AUX_VALUE(12'h000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .touch        (touch),
    .x_value      (x_value),
    .y_value      (y_value),
    .adc_dclk     (adc_dclk),
    .adc_cs_n     (adc_cs_n),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .adc_busy     (adc_busy),
    .adc_penirq_n (adc_penirq_n),
    .cmd_valid    (cmd_valid),
    .last_cmd     (last_cmd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int validCount = 0;

  typedef struct packed {
    logic dout;
    logic busy;
  } expBit_t;

  expBit_t scoreQ[$];
  logic    dinPlan[1:64];
  expBit_t expPlan[1:64];

  // Count cmd_valid pulses away from the active edge
  always @(negedge clk) begin
    if (cmd_valid === 1'b1) validCount++;
  end

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic clearPlan();
    for (int i = 1; i <= 64; i++) begin
      dinPlan[i] = 1'b0;
      expPlan[i] = '0;
    end
  endtask

  function automatic logic [11:0] modelResult(input logic [7:0] cmd);
    logic [11:0] r;
    case (cmd[6:4])
      3'b001:  r = x_value;
      3'b101:  r = y_value;
      default: r = 12'h000;
    endcase
    return r;
  endfunction

  // Plan a command whose start bit lands on dclk rise 'start'
  task automatic addCmd(input int start, input logic [7:0] cmd);
    logic [11:0] res;
    int n;
    res = modelResult(cmd);
    n = cmd[3] ? 8 : 12;
    for (int i = 0; i < 8; i++) dinPlan[start + i] = cmd[7 - i];
    expPlan[start + 8].busy = 1'b1;
    for (int i = 0; i < n; i++) expPlan[start + 9 + i].dout = res[11 - i];
  endtask

  task automatic csLow();
    @(negedge clk);
    adc_cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csHigh();
    @(negedge clk);
    adc_cs_n = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
  endtask

  // Clock out nRises dclk periods; dout/busy sampled just before each rise
  task automatic applyStimulus(input int nRises, input string tag);
    expBit_t e;
    for (int k = 1; k <= nRises; k++) scoreQ.push_back(expPlan[k]);
    for (int k = 1; k <= nRises; k++) begin
      @(negedge clk);
      adc_din = dinPlan[k];
      repeat (HALF - 1) @(negedge clk);
      e = scoreQ.pop_front();
      checkOutput($sformatf("%s_dout_r%0d", tag, k), {31'd0, adc_dout}, {31'd0, e.dout});
      checkOutput($sformatf("%s_busy_r%0d", tag, k), {31'd0, adc_busy}, {31'd0, e.busy});
      adc_dclk = 1'b1;
      repeat (HALF) @(negedge clk);
      adc_dclk = 1'b0;
    end
    adc_din = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    int v0;

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_dout", {31'd0, adc_dout}, 32'd0);
    checkOutput("rst_busy", {31'd0, adc_busy}, 32'd0);
    checkOutput("rst_penirq", {31'd0, adc_penirq_n}, 32'd1);
    checkOutput("rst_valid", {31'd0, cmd_valid}, 32'd0);
    checkOutput("rst_lastcmd", {24'd0, last_cmd}, 32'h00);

    // X conversion, 12-bit
    x_value = 12'hA5C;
    y_value = 12'h3F1;
    clearPlan();
    addCmd(1, 8'h90);
    v0 = validCount;
    csLow();
    applyStimulus(24, "x12");
    csHigh();
    checkOutput("x12_valid_cnt", validCount - v0, 1);
    checkOutput("x12_lastcmd", {24'd0, last_cmd}, 32'h90);

    // Y conversion with panel touched
    touch = 1'b1;
    clearPlan();
    addCmd(1, 8'hD0);
    v0 = validCount;
    csLow();
    applyStimulus(24, "y12");
    checkOutput("y12_penirq_sel", {31'd0, adc_penirq_n}, 32'd1);
    csHigh();
    checkOutput("y12_penirq_desel", {31'd0, adc_penirq_n}, 32'd0);
    checkOutput("y12_valid_cnt", validCount - v0, 1);
    checkOutput("y12_lastcmd", {24'd0, last_cmd}, 32'hD0);

    // 8-bit mode
    clearPlan();
    addCmd(1, 8'h98);
    csLow();
    applyStimulus(24, "x8");
    csHigh();
    checkOutput("x8_lastcmd", {24'd0, last_cmd}, 32'h98);

    // Overlapped commands: second start bit on rise 16
    clearPlan();
    addCmd(1, 8'h90);
    addCmd(16, 8'hD0);
    v0 = validCount;
    csLow();
    applyStimulus(40, "ovl");
    csHigh();
    checkOutput("ovl_valid_cnt", validCount - v0, 2);
    checkOutput("ovl_lastcmd", {24'd0, last_cmd}, 32'hD0);

    // Abort after start bit plus 5 data bits
    clearPlan();
    addCmd(1, 8'h90);
    v0 = validCount;
    csLow();
    applyStimulus(6, "ab5");
    csHigh();
    checkOutput("ab5_busy", {31'd0, adc_busy}, 32'd0);
    checkOutput("ab5_dout", {31'd0, adc_dout}, 32'd0);
    checkOutput("ab5_no_valid", validCount - v0, 0);

    // Abort while busy is high
    clearPlan();
    addCmd(1, 8'h90);
    csLow();
    applyStimulus(8, "abb");
    checkOutput("abb_busy_pre", {31'd0, adc_busy}, 32'd1);
    csHigh();
    checkOutput("abb_busy_post", {31'd0, adc_busy}, 32'd0);

    // Abort in the middle of data output
    clearPlan();
    addCmd(1, 8'h90);
    csLow();
    applyStimulus(14, "abd");
    checkOutput("abd_dout_pre", {31'd0, adc_dout}, 32'd1);
    csHigh();
    checkOutput("abd_dout_post", {31'd0, adc_dout}, 32'd0);
    checkOutput("abd_busy_post", {31'd0, adc_busy}, 32'd0);

    // Fresh full conversion after the aborts
    clearPlan();
    addCmd(1, 8'h90);
    csLow();
    applyStimulus(24, "fresh");
    csHigh();

    // PD0=1 disables pen IRQ; leading zeros before the start bit
    clearPlan();
    addCmd(3, 8'h91);
    csLow();
    applyStimulus(26, "pd1");
    csHigh();
    checkOutput("pd1_lastcmd", {24'd0, last_cmd}, 32'h91);
    checkOutput("pd1_penirq", {31'd0, adc_penirq_n}, 32'd1);
    clearPlan();
    addCmd(1, 8'h90);
    csLow();
    applyStimulus(24, "pd0");
    csHigh();
    checkOutput("pd0_penirq", {31'd0, adc_penirq_n}, 32'd0);

    // Reset asserted mid-transfer
    clearPlan();
    addCmd(1, 8'h90);
    csLow();
    applyStimulus(14, "rmt");
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rmt_dout", {31'd0, adc_dout}, 32'd0);
    checkOutput("rmt_busy", {31'd0, adc_busy}, 32'd0);
    checkOutput("rmt_penirq", {31'd0, adc_penirq_n}, 32'd1);
    checkOutput("rmt_lastcmd", {24'd0, last_cmd}, 32'h00);
    reset_n = 1'b1;
    csHigh();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ad7843_responder.md
Name: ad7843_responder

Overview:
Synthesizable emulator of the AD7843 touch-screen digitizer serial interface. It acts as the SPI-like slave for the LT24 touch-screen driver.
- Accepts 8-bit control bytes on din.
- Pulses busy.
- Shifts out 12-bit or 8-bit conversion results on dout.
- Drives penirq_n from a touch input.
Used for FPGA-in-the-loop and simulation of the touch-screen path without the physical panel.

Parameters:
SYNC_STAGES, 2, synchronizer depth for dclk/cs_n/din (minimum 2)
AUX_VALUE, 12'h000, result returned for any channel other than X or Y

Ports:
clk  in  1  system clock; must be ≥ 8× dclk frequency
reset_n  in  1  synchronous, active-low reset
touch  in  1  1 = panel currently touched
x_value  in  12  X conversion result to return
y_value  in  12  Y conversion result to return
adc_dclk  in  1  serial clock from driver (asynchronous)
adc_cs_n  in  1  chip select, active-low (asynchronous)
adc_din  in  1  serial control data (asynchronous)
adc_dout  out  1  serial result data
adc_busy  out  1  conversion busy flag
adc_penirq_n  out  1  pen interrupt, active-low
cmd_valid  out  1  one-clk pulse when a control byte completes
last_cmd  out  8  most recent complete control byte

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (reset_n).
- Reset values:
  - adc_dout=0, adc_busy=0, adc_penirq_n=1, cmd_valid=0, last_cmd=8'h00.
  - pen IRQ enabled; all shifters cleared; command FSM in IDLE.
- Input conditioning:
  - dclk, cs_n and din each pass through SYNC_STAGES flops plus one edge-detect flop.
  - Rising/falling dclk events are single-clk strobes, valid only while synchronized cs_n=0.
  - Response latency: outputs change SYNC_STAGES+1 clk after a dclk falling edge.
- Command FSM states: IDLE, CMD, BUSY, LOAD.
  - IDLE: on a dclk rise with din=1 (start bit) → CMD, bit counter=1. din=0 rises are ignored (leading zeros).
  - CMD: shift din on each rise, MSB first. After the 8th bit:
    - latch last_cmd, pulse cmd_valid;
    - capture A2:A0=cmd[6:4], MODE=cmd[3], PD0=cmd[0];
    - → BUSY.
  - BUSY: at the next dclk fall, adc_busy=1 → LOAD.
  - LOAD: at the following dclk fall:
    - adc_busy=0;
    - select result: 3'b001 → x_value, 3'b101 → y_value, else AUX_VALUE;
    - if MODE=1, use result[11:4] only;
    - load the output shifter and drive its MSB onto adc_dout;
    - → IDLE.
- Output shifter:
  - Independent of the command FSM.
  - Each dclk fall after a load shifts one bit: 12 bits (or 8 in MODE=1), then 0s.
  - Shifts through BUSY/CMD of a following command, which gives 15-DCLK overlap.
  - A new LOAD overwrites any remaining bits.
- Start-bit search (IDLE) runs concurrently with output shifting. A command may begin during data output.
- Synchronized cs_n high at any time:
  - command FSM → IDLE;
  - adc_busy=0, adc_dout=0, output shifter cleared;
  - last_cmd and PD0 retained.
- Simultaneous cs_n rise and dclk edge: cs_n wins.
- adc_penirq_n = ~(touch & pen_en), where pen_en = ~PD0 of the last completed command (reset: 1). Forced to 1 while cs_n=0.
- reset_n low mid-transfer: all state returns to reset values on that clk edge.

Decomposition:
- Package ad7843_pkg: channel codes (CH_X=3'b001, CH_Y=3'b101), FSM state encoding, control-byte field bit positions, result widths (12/8).
- One sub-module, sync_edge_detect: SYNC_STAGES synchronizer with rise/fall strobes. Instantiated for dclk, cs_n and din (din uses the level output only).

Test Plan:
1. x_value=12'hA5C, send 0x90 (cs_n low, 24 dclk) → cmd_valid pulse, last_cmd=0x90; busy high for exactly one dclk period after the 8th rise; dout on rises 10..21 = 1010_0101_1100; then 0s.
2. y_value=12'h3F1, send 0xD0 → dout=0011_1111_0001; touch=1 gives penirq_n=1 while cs_n=0, 0 after cs_n rises.
3. 8-bit mode: x_value=12'hA5C, send 0x98 → dout=1010_0101 then 0s from the 18th rise onward.
4. 15-clock overlap: 0x90 then 0xD0 whose start bit lands at dclk rise 16 → X word complete and correct; Y word follows without a gap.
5. Abort: raise cs_n after 5 data bits → busy=0, dout=0 within SYNC_STAGES+2 clk; a fresh 0x90 afterwards returns the full 12'hA5C.
6. PD0=1: send 0x91, touch=1, cs_n high → penirq_n stays 1; send 0x90 → penirq_n=0. Leading din=0 rises before the start bit are ignored.
